// File: rtl/pcap_replay_pkg.sv
// Shared types and helpers for the pcap replay address sequencer.
// Holds the per-queue state encoding and the width/slice helper functions.
package pcap_replay_pkg;

  typedef enum logic [1:0] {
    Q_IDLE = 2'd0,
    Q_RUN  = 2'd1,
    Q_DONE = 2'd2
  } q_state_e;

  localparam int DEFAULT_ADDR_STEP = 2;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v * 2) r++;
    return r;
  endfunction

  // A single queue still needs a one-bit index on the request channel.
  function automatic int idx_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  function automatic int slice_lsb(input int q, input int w);
    return q * w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches the request vector starting
// one past the pointer and returns a one-hot grant plus its index.
module rr_arbiter #(
  parameter int C_NUM_QUEUES = 4,
  parameter int Q_IDX_WIDTH  = 2
) (
  input  logic [C_NUM_QUEUES-1:0] req,
  input  logic [Q_IDX_WIDTH-1:0]  ptr,
  output logic [C_NUM_QUEUES-1:0] gnt,
  output logic [Q_IDX_WIDTH-1:0]  gnt_idx,
  output logic                    gnt_valid
);

  logic [Q_IDX_WIDTH-1:0] cand;

  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    cand      = '0;
    for (int i = 1; i <= C_NUM_QUEUES; i++) begin
      cand = Q_IDX_WIDTH'((int'(ptr) + i) % C_NUM_QUEUES);
      if (!gnt_valid && req[cand]) begin
        gnt_valid = 1'b1;
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/pcap_replay_addr_sequencer.sv
// Multi-queue replay address sequencer: walks each queue's QDR region in
// burst steps, loops it a set number of times and merges queues round-robin.
module pcap_replay_addr_sequencer
  import pcap_replay_pkg::*;
#(
  parameter int C_NUM_QUEUES   = 4,
  parameter int QDR_ADDR_WIDTH = 19,
  parameter int ADDR_STEP      = DEFAULT_ADDR_STEP,
  parameter int C_ITER_WIDTH   = 32,
  parameter int Q_IDX_WIDTH    = idx_width(C_NUM_QUEUES)
) (
  input  logic                                   axi_aclk,
  input  logic                                   axi_aresetn,
  input  logic                                   sw_rst,
  input  logic [C_NUM_QUEUES-1:0]                replay_en,
  input  logic [C_NUM_QUEUES*QDR_ADDR_WIDTH-1:0] mem_addr_low,
  input  logic [C_NUM_QUEUES*QDR_ADDR_WIDTH-1:0] mem_addr_high,
  input  logic [C_NUM_QUEUES*C_ITER_WIDTH-1:0]   replay_count,
  input  logic [C_NUM_QUEUES-1:0]                q_ready,
  output logic                                   rd_req_valid,
  input  logic                                   rd_req_ready,
  output logic [QDR_ADDR_WIDTH-1:0]              rd_req_addr,
  output logic [Q_IDX_WIDTH-1:0]                 rd_req_queue,
  output logic                                   rd_req_last,
  output logic [C_NUM_QUEUES-1:0]                replay_done,
  output logic [C_NUM_QUEUES-1:0]                cfg_err,
  output logic [C_NUM_QUEUES*C_ITER_WIDTH-1:0]   iter_cnt
);

  localparam int N   = C_NUM_QUEUES;
  localparam int AW  = QDR_ADDR_WIDTH;
  localparam int IW  = C_ITER_WIDTH;
  localparam int QIW = Q_IDX_WIDTH;

  q_state_e       state_q [N];
  q_state_e       state_d [N];
  logic [AW-1:0]  low_q   [N];
  logic [AW-1:0]  low_d   [N];
  logic [AW-1:0]  high_q  [N];
  logic [AW-1:0]  high_d  [N];
  logic [AW-1:0]  cur_q   [N];
  logic [AW-1:0]  cur_d   [N];
  logic [IW-1:0]  count_q [N];
  logic [IW-1:0]  count_d [N];
  logic [IW-1:0]  iter_q  [N];
  logic [IW-1:0]  iter_d  [N];
  logic [N-1:0]   en_prev_q, en_prev_d;
  logic [N-1:0]   done_q, done_d;
  logic [N-1:0]   err_q, err_d;

  logic           vld_q, vld_d;
  logic           last_q, last_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [QIW-1:0] queue_q, queue_d;
  logic [QIW-1:0] ptr_q, ptr_d;

  logic [AW-1:0]  cfg_low   [N];
  logic [AW-1:0]  cfg_high  [N];
  logic [IW-1:0]  cfg_count [N];

  logic [N-1:0]   eligible;
  logic [N-1:0]   gnt;
  logic [QIW-1:0] gnt_idx;
  logic           gnt_valid;
  logic           grant;
  logic [AW:0]    step_sum;
  logic [IW-1:0]  iter_next;

  always_comb begin
    for (int q = 0; q < N; q++) begin
      cfg_low[q]   = mem_addr_low[slice_lsb(q, AW) +: AW];
      cfg_high[q]  = mem_addr_high[slice_lsb(q, AW) +: AW];
      cfg_count[q] = replay_count[slice_lsb(q, IW) +: IW];
      eligible[q]  = (state_q[q] == Q_RUN) && replay_en[q] && q_ready[q];
    end
  end

  rr_arbiter #(
    .C_NUM_QUEUES (N),
    .Q_IDX_WIDTH  (QIW)
  ) u_arb (
    .req       (eligible),
    .ptr       (ptr_q),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  // The output slot can take a new request when empty or being drained now.
  assign grant = gnt_valid && (!vld_q || rd_req_ready);

  always_comb begin
    en_prev_d = replay_en;
    done_d    = done_q;
    err_d     = err_q;
    ptr_d     = ptr_q;
    vld_d     = vld_q;
    addr_d    = addr_q;
    queue_d   = queue_q;
    last_d    = last_q;
    step_sum  = '0;
    iter_next = '0;

    if (vld_q && rd_req_ready) vld_d = 1'b0;
    if (grant) begin
      vld_d   = 1'b1;
      queue_d = gnt_idx;
      ptr_d   = gnt_idx;
    end

    for (int q = 0; q < N; q++) begin
      state_d[q] = state_q[q];
      low_d[q]   = low_q[q];
      high_d[q]  = high_q[q];
      cur_d[q]   = cur_q[q];
      count_d[q] = count_q[q];
      iter_d[q]  = iter_q[q];

      case (state_q[q])
        Q_IDLE: begin
          if (replay_en[q] && !en_prev_q[q]) begin
            low_d[q]   = cfg_low[q];
            high_d[q]  = cfg_high[q];
            count_d[q] = cfg_count[q];
            cur_d[q]   = cfg_low[q];
            iter_d[q]  = '0;
            done_d[q]  = 1'b0;
            err_d[q]   = 1'b0;
            state_d[q] = Q_RUN;
            if (cfg_low[q] > cfg_high[q]) begin
              state_d[q] = Q_DONE;
              err_d[q]   = 1'b1;
              done_d[q]  = 1'b1;
            end
          end
        end
        Q_RUN: begin
          if (!replay_en[q]) begin
            state_d[q] = Q_IDLE;
          end else if (grant && gnt[q]) begin
            // Extra carry bit keeps the wrap test correct at the top of memory.
            step_sum = {1'b0, cur_q[q]} + (AW+1)'(ADDR_STEP);
            addr_d   = cur_q[q];
            if (step_sum > {1'b0, high_q[q]}) begin
              iter_next = iter_q[q] + IW'(1);
              last_d    = 1'b1;
              cur_d[q]  = low_q[q];
              iter_d[q] = iter_next;
              if ((count_q[q] != '0) && (iter_next == count_q[q])) begin
                state_d[q] = Q_DONE;
                done_d[q]  = 1'b1;
              end
            end else begin
              last_d   = 1'b0;
              cur_d[q] = step_sum[AW-1:0];
            end
          end
        end
        Q_DONE: begin
          if (!replay_en[q]) state_d[q] = Q_IDLE;
        end
        default: state_d[q] = Q_IDLE;
      endcase
    end

    if (sw_rst) begin
      en_prev_d = '0;
      done_d    = '0;
      err_d     = '0;
      ptr_d     = QIW'(N - 1);
      vld_d     = 1'b0;
      addr_d    = '0;
      queue_d   = '0;
      last_d    = 1'b0;
      for (int q = 0; q < N; q++) begin
        state_d[q] = Q_IDLE;
        low_d[q]   = '0;
        high_d[q]  = '0;
        cur_d[q]   = '0;
        count_d[q] = '0;
        iter_d[q]  = '0;
      end
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      en_prev_q <= '0;
      done_q    <= '0;
      err_q     <= '0;
      ptr_q     <= QIW'(N - 1);
      vld_q     <= 1'b0;
      addr_q    <= '0;
      queue_q   <= '0;
      last_q    <= 1'b0;
      for (int q = 0; q < N; q++) begin
        state_q[q] <= Q_IDLE;
        low_q[q]   <= '0;
        high_q[q]  <= '0;
        cur_q[q]   <= '0;
        count_q[q] <= '0;
        iter_q[q]  <= '0;
      end
    end else begin
      en_prev_q <= en_prev_d;
      done_q    <= done_d;
      err_q     <= err_d;
      ptr_q     <= ptr_d;
      vld_q     <= vld_d;
      addr_q    <= addr_d;
      queue_q   <= queue_d;
      last_q    <= last_d;
      state_q   <= state_d;
      low_q     <= low_d;
      high_q    <= high_d;
      cur_q     <= cur_d;
      count_q   <= count_d;
      iter_q    <= iter_d;
    end
  end

  always_comb begin
    iter_cnt = '0;
    for (int q = 0; q < N; q++) iter_cnt[slice_lsb(q, IW) +: IW] = iter_q[q];
  end

  assign rd_req_valid = vld_q;
  assign rd_req_addr  = addr_q;
  assign rd_req_queue = queue_q;
  assign rd_req_last  = last_q;
  assign replay_done  = done_q;
  assign cfg_err      = err_q;

endmodule

// File: tb/tb_pcap_replay_addr_sequencer.sv
// Directed bench for pcap_replay_addr_sequencer with hand-computed address
// sequences for looping, backpressure, arbitration, wrap, abort and reset.
module tb_pcap_replay_addr_sequencer;

  localparam int N  = 4;
  localparam int AW = 19;
  localparam int IW = 32;
  localparam int QW = 2;

  logic              axi_aclk = 1'b0;
  logic              axi_aresetn;
  logic              sw_rst;
  logic [N-1:0]      replay_en;
  logic [N*AW-1:0]   mem_addr_low;
  logic [N*AW-1:0]   mem_addr_high;
  logic [N*IW-1:0]   replay_count;
  logic [N-1:0]      q_ready;
  logic              rd_req_valid;
  logic              rd_req_ready;
  logic [AW-1:0]     rd_req_addr;
  logic [QW-1:0]     rd_req_queue;
  logic              rd_req_last;
  logic [N-1:0]      replay_done;
  logic [N-1:0]      cfg_err;
  logic [N*IW-1:0]   iter_cnt;

  int vecCount = 0;
  int errCount = 0;

  always #5 axi_aclk = ~axi_aclk;

  pcap_replay_addr_sequencer #(
    .C_NUM_QUEUES   (N),
    .QDR_ADDR_WIDTH (AW),
    .ADDR_STEP      (2),
    .C_ITER_WIDTH   (IW)
  ) dut (
    .axi_aclk      (axi_aclk),
    .axi_aresetn   (axi_aresetn),
    .sw_rst        (sw_rst),
    .replay_en     (replay_en),
    .mem_addr_low  (mem_addr_low),
    .mem_addr_high (mem_addr_high),
    .replay_count  (replay_count),
    .q_ready       (q_ready),
    .rd_req_valid  (rd_req_valid),
    .rd_req_ready  (rd_req_ready),
    .rd_req_addr   (rd_req_addr),
    .rd_req_queue  (rd_req_queue),
    .rd_req_last   (rd_req_last),
    .replay_done   (replay_done),
    .cfg_err       (cfg_err),
    .iter_cnt      (iter_cnt)
  );

  task automatic tick();
    @(posedge axi_aclk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input int q, input logic [AW-1:0] lo, input logic [AW-1:0] hi,
                               input logic [IW-1:0] cnt);
    mem_addr_low[q*AW +: AW]  = lo;
    mem_addr_high[q*AW +: AW] = hi;
    replay_count[q*IW +: IW]  = cnt;
  endtask

  function automatic logic [IW-1:0] iterOf(input int q);
    return iter_cnt[q*IW +: IW];
  endfunction

  task automatic checkReq(input string tag, input logic [AW-1:0] addr, input int q, input logic last);
    checkOutput({tag, " valid"}, 64'(rd_req_valid), 64'd1);
    checkOutput({tag, " addr"},  64'(rd_req_addr), 64'(addr));
    checkOutput({tag, " queue"}, 64'(rd_req_queue), 64'(q));
    checkOutput({tag, " last"},  64'(rd_req_last), 64'(last));
  endtask

  task automatic resetDut();
    replay_en    = '0;
    q_ready      = '1;
    rd_req_ready = 1'b1;
    sw_rst       = 1'b1;
    tick();
    sw_rst       = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [AW-1:0] loopAddr [8];
    loopAddr = '{19'h10, 19'h12, 19'h14, 19'h16, 19'h10, 19'h12, 19'h14, 19'h16};

    axi_aresetn   = 1'b0;
    sw_rst        = 1'b0;
    replay_en     = '0;
    mem_addr_low  = '0;
    mem_addr_high = '0;
    replay_count  = '0;
    q_ready       = '1;
    rd_req_ready  = 1'b1;
    #12;
    checkOutput("reset valid", 64'(rd_req_valid), 64'd0);
    checkOutput("reset done",  64'(replay_done), 64'd0);
    checkOutput("reset err",   64'(cfg_err), 64'd0);
    checkOutput("reset iter",  64'(|iter_cnt), 64'd0);
    axi_aresetn = 1'b1;
    tick();

    // Two passes of an 8-word region on queue 0.
    applyStimulus(0, 19'h10, 19'h17, 32'd2);
    replay_en[0] = 1'b1;
    tick();
    checkOutput("loop latency", 64'(rd_req_valid), 64'd0);
    for (int k = 0; k < 8; k++) begin
      tick();
      checkReq($sformatf("loop req%0d", k), loopAddr[k], 0, (k == 3) || (k == 7));
    end
    tick();
    checkOutput("loop end valid", 64'(rd_req_valid), 64'd0);
    checkOutput("loop done", 64'(replay_done[0]), 64'd1);
    checkOutput("loop iter", 64'(iterOf(0)), 64'd2);
    replay_en[0] = 1'b0;
    tick();
    tick();
    checkOutput("idle done hold", 64'(replay_done[0]), 64'd1);
    checkOutput("idle iter hold", 64'(iterOf(0)), 64'd2);

    resetDut();
    checkOutput("swrst done", 64'(replay_done), 64'd0);
    checkOutput("swrst iter", 64'(iterOf(0)), 64'd0);

    // Backpressure holds the presented request steady.
    applyStimulus(0, 19'h40, 19'h4F, 32'd0);
    replay_en[0] = 1'b1;
    tick();
    tick();
    checkReq("bp a", 19'h40, 0, 1'b0);
    tick();
    checkReq("bp b", 19'h42, 0, 1'b0);
    rd_req_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      checkReq($sformatf("bp hold%0d", k), 19'h42, 0, 1'b0);
    end
    rd_req_ready = 1'b1;
    tick();
    checkReq("bp resume", 19'h44, 0, 1'b0);
    tick();
    checkReq("bp next", 19'h46, 0, 1'b0);
    replay_en[0] = 1'b0;
    tick();
    checkOutput("stop valid", 64'(rd_req_valid), 64'd0);

    resetDut();
    // Round-robin between q0 and q1, then q1 stalled by its FIFO.
    applyStimulus(0, 19'h100, 19'h107, 32'd0);
    applyStimulus(1, 19'h200, 19'h207, 32'd0);
    replay_en[1:0] = 2'b11;
    tick();
    tick();
    checkReq("rr 0", 19'h100, 0, 1'b0);
    tick();
    checkReq("rr 1", 19'h200, 1, 1'b0);
    tick();
    checkReq("rr 2", 19'h102, 0, 1'b0);
    tick();
    checkReq("rr 3", 19'h202, 1, 1'b0);
    q_ready[1] = 1'b0;
    tick();
    checkReq("rr q0only a", 19'h104, 0, 1'b0);
    tick();
    checkReq("rr q0only b", 19'h106, 0, 1'b1);
    tick();
    checkReq("rr q0only c", 19'h100, 0, 1'b0);
    q_ready[1] = 1'b1;
    tick();
    checkReq("rr q1 resume", 19'h204, 1, 1'b0);
    tick();
    checkReq("rr q0 again", 19'h102, 0, 1'b0);
    replay_en = '0;
    tick();

    resetDut();
    // Region touching the top of the address space, infinite loop on q2.
    applyStimulus(2, 19'h7FFF0, 19'h7FFFF, 32'd0);
    replay_en[2] = 1'b1;
    tick();
    for (int k = 0; k < 8; k++) begin
      tick();
      checkReq($sformatf("top req%0d", k), 19'h7FFF0 + 19'(2 * k), 2, k == 7);
    end
    tick();
    checkReq("top wrap", 19'h7FFF0, 2, 1'b0);
    checkOutput("top iter", 64'(iterOf(2)), 64'd1);
    checkOutput("top done", 64'(replay_done[2]), 64'd0);
    replay_en[2] = 1'b0;
    tick();

    resetDut();
    // Inverted region on q3 must fail without issuing requests.
    applyStimulus(3, 19'h20, 19'h10, 32'd5);
    replay_en[3] = 1'b1;
    tick();
    checkOutput("cfg err", 64'(cfg_err[3]), 64'd1);
    checkOutput("cfg done", 64'(replay_done[3]), 64'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput($sformatf("cfg noreq%0d", k), 64'(rd_req_valid), 64'd0);
    end
    replay_en[3] = 1'b0;
    tick();

    resetDut();
    // Abort q1 mid-run after one completed pass.
    applyStimulus(1, 19'h30, 19'h33, 32'd0);
    replay_en[1] = 1'b1;
    tick();
    tick();
    checkReq("abort a", 19'h30, 1, 1'b0);
    tick();
    checkReq("abort b", 19'h32, 1, 1'b1);
    tick();
    checkReq("abort c", 19'h30, 1, 1'b0);
    replay_en[1] = 1'b0;
    tick();
    checkOutput("abort stop", 64'(rd_req_valid), 64'd0);
    tick();
    checkOutput("abort idle", 64'(rd_req_valid), 64'd0);
    checkOutput("abort iter hold", 64'(iterOf(1)), 64'd1);
    checkOutput("abort done", 64'(replay_done[1]), 64'd0);

    resetDut();
    // Asynchronous reset while a request is presented.
    applyStimulus(0, 19'h10, 19'h17, 32'd0);
    replay_en[0] = 1'b1;
    tick();
    tick();
    checkReq("arst pre a", 19'h10, 0, 1'b0);
    tick();
    checkReq("arst pre b", 19'h12, 0, 1'b0);
    axi_aresetn = 1'b0;
    #1;
    checkOutput("arst valid", 64'(rd_req_valid), 64'd0);
    checkOutput("arst addr",  64'(rd_req_addr), 64'd0);
    checkOutput("arst last",  64'(rd_req_last), 64'd0);
    checkOutput("arst iter",  64'(|iter_cnt), 64'd0);
    replay_en = '0;
    #1;
    axi_aresetn = 1'b1;
    tick();
    replay_en[0] = 1'b1;
    tick();
    checkOutput("arst restart latency", 64'(rd_req_valid), 64'd0);
    tick();
    checkReq("arst restart", 19'h10, 0, 1'b0);
    replay_en = '0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
